// File: rtl/buffer_dma.sv
// buffer_dma: moves descriptor-sized blocks of words between external memory
// and the two on-chip buffer banks, one word per cycle. It hides a fixed
// external read latency (LOAD) and the one-cycle buffer read latency (SAVE).
module buffer_dma #(
    parameter int DATA_W    = 16,
    parameter int ADDR_RAM  = 10,
    parameter int LOG_N_BUF = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [31:0]          req_ext_addr,
    input  logic [31:0]          req_words,
    input  logic                 req_buf_bank,
    input  logic [LOG_N_BUF-1:0] req_buf_idx,
    input  logic [ADDR_RAM-1:0]  req_buf_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 ext_re,
    output logic [31:0]          ext_rd_addr,
    input  logic [DATA_W-1:0]    ext_rd_data,
    output logic                 ext_we,
    output logic [31:0]          ext_wr_addr,
    output logic [DATA_W-1:0]    ext_wr_data,
    output logic                 buf_w_en,
    output logic                 buf_w_bank,
    output logic [LOG_N_BUF-1:0] buf_w_idx,
    output logic [ADDR_RAM-1:0]  buf_w_addr,
    output logic [DATA_W-1:0]    buf_w_data,
    output logic                 buf_r_en,
    output logic                 buf_r_bank,
    output logic [LOG_N_BUF-1:0] buf_r_idx,
    output logic [ADDR_RAM-1:0]  buf_r_addr,
    input  logic [DATA_W-1:0]    buf1_r_data,
    input  logic [DATA_W-1:0]    buf2_r_data
);

    typedef enum logic [1:0] {IDLE, LOAD, SAVE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   op_q, op_d;
    logic [31:0]            ext_addr_q, ext_addr_d;
    logic [31:0]            words_q, words_d;
    logic                   bank_q, bank_d;
    logic [LOG_N_BUF-1:0]   idx_q, idx_d;
    logic [ADDR_RAM-1:0]    buf_addr_q, buf_addr_d;
    logic [31:0]            k_q, k_d;
    logic [31:0]            j_q, j_d;
    // In-flight tracker: bit 0 is set the cycle after an issue. SAVE taps
    // bit 0 (buffer latency 1), LOAD taps bit RD_LAT-1.
    logic [RD_LAT-1:0]      vld_q, vld_d;

    logic                   issue;
    logic                   wr_fire;
    logic                   last_wr;
    logic                   done_c;

    // Issue / write-completion decode from registered state
    always_comb begin
        issue   = ((state_q == LOAD) || (state_q == SAVE)) && (k_q < words_q);
        wr_fire = (state_q != IDLE) && (op_q ? vld_q[0] : vld_q[RD_LAT-1]);
        last_wr = wr_fire && (j_q == words_q - 32'd1);
        done_c  = (state_q == DRAIN) && ((words_q == 32'd0) || last_wr);
    end

    // Next-state, descriptor latch and counter updates
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ext_addr_d = ext_addr_q;
        words_d    = words_q;
        bank_d     = bank_q;
        idx_d      = idx_q;
        buf_addr_d = buf_addr_q;
        k_d        = k_q;
        j_d        = wr_fire ? j_q + 32'd1 : j_q;
        vld_d[0]   = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    ext_addr_d = req_ext_addr;
                    words_d    = req_words;
                    bank_d     = req_buf_bank;
                    idx_d      = req_buf_idx;
                    buf_addr_d = req_buf_addr;
                    k_d        = 32'd0;
                    j_d        = 32'd0;
                    // Leftover SAVE bits in the deeper taps must not leak
                    // into a following LOAD.
                    vld_d      = '0;
                    if (req_words == 32'd0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = req_op ? SAVE : LOAD;
                    end
                end
            end
            LOAD, SAVE: begin
                if (issue) begin
                    k_d = k_q + 32'd1;
                    if (k_q == words_q - 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine state registers; reset abandons any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            ext_addr_q <= '0;
            words_q    <= '0;
            bank_q     <= 1'b0;
            idx_q      <= '0;
            buf_addr_q <= '0;
            k_q        <= '0;
            j_q        <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ext_addr_q <= ext_addr_d;
            words_q    <= words_d;
            bank_q     <= bank_d;
            idx_q      <= idx_d;
            buf_addr_q <= buf_addr_d;
            k_q        <= k_d;
            j_q        <= j_d;
            vld_q      <= vld_d;
        end
    end

    // Memory/buffer ports; addresses and data are zero whenever not strobed
    always_comb begin
        req_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        done        = done_c;

        ext_re      = issue && !op_q;
        ext_rd_addr = ext_re ? ext_addr_q + k_q : 32'd0;

        buf_r_en    = issue && op_q;
        buf_r_bank  = buf_r_en ? bank_q : 1'b0;
        buf_r_idx   = buf_r_en ? idx_q : '0;
        buf_r_addr  = buf_r_en ? buf_addr_q + k_q[ADDR_RAM-1:0] : '0;

        buf_w_en    = wr_fire && !op_q;
        buf_w_bank  = buf_w_en ? bank_q : 1'b0;
        buf_w_idx   = buf_w_en ? idx_q : '0;
        buf_w_addr  = buf_w_en ? buf_addr_q + j_q[ADDR_RAM-1:0] : '0;
        buf_w_data  = buf_w_en ? ext_rd_data : '0;

        ext_we      = wr_fire && op_q;
        ext_wr_addr = ext_we ? ext_addr_q + j_q : 32'd0;
        ext_wr_data = ext_we ? (bank_q ? buf2_r_data : buf1_r_data) : '0;
    end

endmodule

// File: tb/tb_buffer_dma.sv
// Testbench for buffer_dma: directed and random descriptors; expected strobes
// are queued per stream with their cycle number and checked by a monitor.
module tb_buffer_dma;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_op, req_buf_bank;
    logic [31:0] req_ext_addr, req_words;
    logic [7:0]  req_buf_idx;
    logic [9:0]  req_buf_addr;
    logic        busy, done;
    logic        ext_re, ext_we;
    logic [31:0] ext_rd_addr, ext_wr_addr;
    logic [15:0] ext_rd_data, ext_wr_data;
    logic        buf_w_en, buf_w_bank, buf_r_en, buf_r_bank;
    logic [7:0]  buf_w_idx, buf_r_idx;
    logic [9:0]  buf_w_addr, buf_r_addr;
    logic [15:0] buf_w_data, buf1_r_data, buf2_r_data;

    buffer_dma #(.DATA_W(16), .ADDR_RAM(10), .LOG_N_BUF(8), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_ext_addr(req_ext_addr), .req_words(req_words),
        .req_buf_bank(req_buf_bank), .req_buf_idx(req_buf_idx), .req_buf_addr(req_buf_addr),
        .busy(busy), .done(done),
        .ext_re(ext_re), .ext_rd_addr(ext_rd_addr), .ext_rd_data(ext_rd_data),
        .ext_we(ext_we), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
        .buf_w_en(buf_w_en), .buf_w_bank(buf_w_bank), .buf_w_idx(buf_w_idx),
        .buf_w_addr(buf_w_addr), .buf_w_data(buf_w_data),
        .buf_r_en(buf_r_en), .buf_r_bank(buf_r_bank), .buf_r_idx(buf_r_idx),
        .buf_r_addr(buf_r_addr),
        .buf1_r_data(buf1_r_data), .buf2_r_data(buf2_r_data)
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [15:0] d;
        logic        b;
        logic [7:0]  ix;
    } ev_t;

    ev_t q_rd[$], q_bw[$], q_br[$], q_ew[$];
    int  q_done[$];
    int  cyc = 0;
    int  idle_from = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    bit          hv[8];
    logic [31:0] ha[8];
    logic        br_v = 1'b0;
    logic [9:0]  br_a = '0;
    logic [7:0]  br_ix = '0;

    function automatic logic [15:0] fmem(input logic [31:0] a);
        return a[15:0] ^ {a[23:16], a[31:24]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] fbuf(input logic b, input logic [7:0] ix, input logic [9:0] a);
        return {ix, 8'h00} ^ {6'b0, a} ^ (b ? 16'hC0DE : 16'h1234);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External memory and buffer bank models (read latency LAT and 1)
    always @(posedge clk) begin
        #1;
        if (hv[(cyc + 8 - LAT) % 8]) ext_rd_data = fmem(ha[(cyc + 8 - LAT) % 8]);
        else ext_rd_data = 16'($urandom);
        buf1_r_data = br_v ? fbuf(1'b0, br_ix, br_a) : 16'($urandom);
        buf2_r_data = br_v ? fbuf(1'b1, br_ix, br_a) : 16'($urandom);
    end

    always @(negedge clk) begin
        hv[cyc % 8] <= ext_re;
        ha[cyc % 8] <= ext_rd_addr;
        br_v        <= buf_r_en;
        br_a        <= buf_r_addr;
        br_ix       <= buf_r_idx;
    end

    // Monitor: every cycle, each stream either matches its queued event or is quiet
    always @(negedge clk) begin
        ev_t e;
        int  dc;
        chk("req_ready", req_ready, cyc >= idle_from);
        chk("busy", busy, cyc < idle_from);
        if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
            e = q_rd.pop_front();
            chk("ext_re", ext_re, 1);
            chk("ext_rd_addr", ext_rd_addr, e.a);
        end else chk("ext_re_quiet", ext_re, 0);
        if (q_bw.size() > 0 && q_bw[0].cyc == cyc) begin
            e = q_bw.pop_front();
            chk("buf_w_en", buf_w_en, 1);
            chk("buf_w_addr", buf_w_addr, e.a);
            chk("buf_w_data", buf_w_data, e.d);
            chk("buf_w_bank", buf_w_bank, e.b);
            chk("buf_w_idx", buf_w_idx, e.ix);
        end else chk("buf_w_quiet", buf_w_en, 0);
        if (q_br.size() > 0 && q_br[0].cyc == cyc) begin
            e = q_br.pop_front();
            chk("buf_r_en", buf_r_en, 1);
            chk("buf_r_addr", buf_r_addr, e.a);
            chk("buf_r_bank", buf_r_bank, e.b);
            chk("buf_r_idx", buf_r_idx, e.ix);
        end else chk("buf_r_quiet", buf_r_en, 0);
        if (q_ew.size() > 0 && q_ew[0].cyc == cyc) begin
            e = q_ew.pop_front();
            chk("ext_we", ext_we, 1);
            chk("ext_wr_addr", ext_wr_addr, e.a);
            chk("ext_wr_data", ext_wr_data, e.d);
        end else chk("ext_we_quiet", ext_we, 0);
        if (q_done.size() > 0 && q_done[0] == cyc) begin
            dc = q_done.pop_front();
            chk("done", done, 1);
        end else chk("done_quiet", done, 0);
    end

    // Present a descriptor, wait for acceptance, queue the expected response
    task automatic issue(input logic op, input logic [31:0] ea, input logic [31:0] n,
                         input logic bk, input logic [7:0] ix, input logic [9:0] ba,
                         input logic hold, output int a);
        int w = 0;
        int dcyc;
        req_valid    = 1'b1;
        req_op       = op;
        req_ext_addr = ea;
        req_words    = n;
        req_buf_bank = bk;
        req_buf_idx  = ix;
        req_buf_addr = ba;
        @(negedge clk);
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", w < 300, 1);
        a = cyc;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            if (!op) begin
                q_rd.push_back('{a + 1 + i, ea + 32'(i), 16'h0, 1'b0, 8'h0});
                q_bw.push_back('{a + 1 + LAT + i, {22'b0, ba + 10'(i)}, fmem(ea + 32'(i)), bk, ix});
            end else begin
                q_br.push_back('{a + 1 + i, {22'b0, ba + 10'(i)}, 16'h0, bk, ix});
                q_ew.push_back('{a + 2 + i, ea + 32'(i), fbuf(bk, ix, ba + 10'(i)), 1'b0, 8'h0});
            end
        end
        if (n == 0) dcyc = a + 1;
        else if (op) dcyc = a + int'(n) + 1;
        else dcyc = a + int'(n) + LAT;
        q_done.push_back(dcyc);
        idle_from = dcyc + 1;
    endtask

    initial begin
        int a1, a2, w;
        rst = 1'b1;
        req_valid = 1'b0; req_op = 1'b0; req_ext_addr = '0; req_words = '0;
        req_buf_bank = 1'b0; req_buf_idx = '0; req_buf_addr = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ext_re", ext_re, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Wrapping LOAD, bank-1 SAVE, empty transfer
        issue(1'b0, 32'h100, 4, 1'b0, 8'd3, 10'h3FE, 1'b0, a1);
        issue(1'b1, 32'h20, 3, 1'b1, 8'h11, 10'h050, 1'b0, a1);
        issue(1'b0, 32'h40, 0, 1'b1, 8'h22, 10'h100, 1'b0, a1);
        // req_valid held high: next descriptor only taken once idle again
        issue(1'b0, 32'h200, 2, 1'b1, 8'd5, 10'h010, 1'b1, a1);
        issue(1'b1, 32'h300, 2, 1'b0, 8'd7, 10'h020, 1'b0, a2);
        chk("reaccept_cycle", a2 - a1, 2 + LAT + 1);
        // External address wrap
        issue(1'b0, 32'hFFFF_FFFF, 2, 1'b0, 8'd9, 10'h000, 1'b0, a1);

        // Reset in cycle 3 of a 10-word LOAD
        issue(1'b0, 32'h1000, 10, 1'b0, 8'd1, 10'h000, 1'b0, a1);
        while (cyc < a1 + 3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_ext_re", ext_re, 0);
        chk("mid_rst_rd_addr", ext_rd_addr, 0);
        chk("mid_rst_buf_w_en", buf_w_en, 0);
        chk("mid_rst_buf_w_addr", buf_w_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        q_rd.delete(); q_bw.delete(); q_br.delete(); q_ew.delete(); q_done.delete();
        idle_from = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(1'b0, 32'h2000, 1, 1'b1, 8'd9, 10'h3FF, 1'b0, a1);

        // Random descriptors, with gaps and held-valid back-to-back runs
        for (int t = 0; t < 40; t++) begin
            logic [31:0] ea;
            ea = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom;
            issue(1'($urandom_range(0, 1)), ea, 32'($urandom_range(0, 9)),
                  1'($urandom_range(0, 1)), 8'($urandom), 10'($urandom),
                  1'($urandom_range(0, 1)), a1);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;

        w = 0;
        while ((q_rd.size() + q_bw.size() + q_br.size() + q_ew.size() + q_done.size()) != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        chk("drain_wait", w < 500, 1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
